// File: rtl/otp_auth_ctrl.sv
// otp_auth_ctrl: one-time-password entry controller with an attempt limit and an entry window.
// Define OTP_LOCKOUT_EN to add a timed LOCKOUT stage after FAIL; without it FAIL returns to IDLE.
module otp_auth_ctrl #(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned EXPIRE_CYCLES  = 1_500_000_000,
    parameter int unsigned HOLD_CYCLES    = 250_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_DIGITS*DIGIT_W-1:0]   lfsr_code,
    input  logic                          lfsr_latch,
    input  logic [DIGIT_W-1:0]            user_digit,
    input  logic                          user_latch,
    input  logic                          user_clear,
    output logic                          unlock,
    output logic                          reset_sys,
    output logic                          expired,
    output logic                          locked,
    output logic [3:0]                    wrng_atmpt,
    output logic [N_DIGITS*DIGIT_W-1:0]   otp,
    output logic [N_DIGITS*DIGIT_W-1:0]   user_otp_out,
    output logic [3:0]                    digit_cnt,
    output logic [2:0]                    state_out
);

    // state   | meaning
    // IDLE    | clear everything, go to GEN
    // GEN     | wait for lfsr_latch, capture code
    // ENTER   | collect digits, entry window running
    // CHECK   | one-cycle compare of entry against code
    // PASS    | unlock held for HOLD_CYCLES
    // FAIL    | reset_sys held for HOLD_CYCLES
    // EXPIRED | expired held for HOLD_CYCLES
    // LOCKOUT | locked held for LOCKOUT_CYCLES (OTP_LOCKOUT_EN only)
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GEN     = 3'd1,
        ENTER   = 3'd2,
        CHECK   = 3'd3,
        PASS    = 3'd4,
        FAIL    = 3'd5,
        EXPIRED = 3'd6
`ifdef OTP_LOCKOUT_EN
        , LOCKOUT = 3'd7
`endif
    } state_t;

    localparam int unsigned CODE_W    = N_DIGITS * DIGIT_W;
    localparam logic [31:0] EXP_LAST  = 32'(EXPIRE_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [3:0]  N_DIG     = 4'(N_DIGITS);
    localparam logic [3:0]  MAX_ATT   = 4'(MAX_ATTEMPTS);

    if (N_DIGITS < 2 || N_DIGITS > 8 || DIGIT_W < 1 || MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15 ||
        EXPIRE_CYCLES < 1 || HOLD_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : g_param_check
        $error("otp_auth_ctrl: parameter out of range");
    end

    state_t              state, state_nxt;
    logic [CODE_W-1:0]   otp_nxt, user_nxt;
    logic [3:0]          cnt_nxt, wrng_nxt, wrng_inc;
    logic [31:0]         entry_tmr, entry_nxt;
    logic [31:0]         hold_cnt, hold_nxt;

    assign state_out = state;
    assign wrng_inc  = (wrng_atmpt == MAX_ATT) ? MAX_ATT : wrng_atmpt + 4'd1;

    always_comb begin
        state_nxt = state;
        otp_nxt   = otp;
        user_nxt  = user_otp_out;
        cnt_nxt   = digit_cnt;
        wrng_nxt  = wrng_atmpt;
        entry_nxt = entry_tmr;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                otp_nxt   = '0;
                user_nxt  = '0;
                cnt_nxt   = '0;
                wrng_nxt  = '0;
                entry_nxt = '0;
                hold_nxt  = '0;
                state_nxt = GEN;
            end
            GEN: begin
                if (lfsr_latch) begin
                    otp_nxt   = lfsr_code;
                    entry_nxt = '0;
                    state_nxt = ENTER;
                end
            end
            ENTER: begin
                entry_nxt = entry_tmr + 32'd1;
                // expiry outranks everything, including a digit strobed in the same cycle
                if (entry_tmr == EXP_LAST) begin
                    hold_nxt  = '0;
                    state_nxt = EXPIRED;
                end else if (digit_cnt == N_DIG) begin
                    state_nxt = CHECK;
                end else if (user_clear) begin
                    user_nxt = '0;
                    cnt_nxt  = '0;
                end else if (user_latch) begin
                    for (int i = 0; i < int'(N_DIGITS); i++) begin
                        if (4'(i) == digit_cnt)
                            user_nxt[(int'(N_DIGITS) - 1 - i) * int'(DIGIT_W) +: DIGIT_W] = user_digit;
                    end
                    cnt_nxt = digit_cnt + 4'd1;
                end
            end
            CHECK: begin
                hold_nxt = '0;
                if (otp == user_otp_out) begin
                    state_nxt = PASS;
                end else begin
                    wrng_nxt = wrng_inc;
                    if (wrng_inc == MAX_ATT) begin
                        state_nxt = FAIL;
                    end else begin
                        user_nxt  = '0;
                        cnt_nxt   = '0;
                        state_nxt = ENTER;
                    end
                end
            end
            PASS, EXPIRED: begin
                if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
                else                       hold_nxt  = hold_cnt + 32'd1;
            end
            FAIL: begin
                if (hold_cnt == HOLD_LAST) begin
`ifdef OTP_LOCKOUT_EN
                    hold_nxt  = '0;
                    state_nxt = LOCKOUT;
`else
                    state_nxt = IDLE;
`endif
                end else begin
                    hold_nxt = hold_cnt + 32'd1;
                end
            end
`ifdef OTP_LOCKOUT_EN
            LOCKOUT: begin
                if (hold_cnt == 32'(LOCKOUT_CYCLES - 1)) state_nxt = IDLE;
                else                                    hold_nxt  = hold_cnt + 32'd1;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            otp          <= '0;
            user_otp_out <= '0;
            digit_cnt    <= '0;
            wrng_atmpt   <= '0;
            entry_tmr    <= '0;
            hold_cnt     <= '0;
            unlock       <= 1'b0;
            reset_sys    <= 1'b0;
            expired      <= 1'b0;
        end else begin
            state        <= state_nxt;
            otp          <= otp_nxt;
            user_otp_out <= user_nxt;
            digit_cnt    <= cnt_nxt;
            wrng_atmpt   <= wrng_nxt;
            entry_tmr    <= entry_nxt;
            hold_cnt     <= hold_nxt;
            unlock       <= (state_nxt == PASS);
            reset_sys    <= (state_nxt == FAIL);
            expired      <= (state_nxt == EXPIRED);
        end
    end

`ifdef OTP_LOCKOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) locked <= 1'b0;
        else       locked <= (state_nxt == LOCKOUT);
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// tb_otp_auth_ctrl: directed scenarios for otp_auth_ctrl (4-digit instance plus a 6-digit instance).
// Honours OTP_LOCKOUT_EN when the design is built with it.
module tb_otp_auth_ctrl;

    localparam int unsigned EXP  = 100;
    localparam int unsigned HOLD = 10;
    localparam int unsigned LOCK = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] lfsr_code;
    logic        lfsr_latch, user_latch, user_clear;
    logic [3:0]  user_digit;
    logic        unlock, reset_sys, expired, locked;
    logic [3:0]  wrng_atmpt, digit_cnt;
    logic [15:0] otp, user_otp_out;
    logic [2:0]  state_out;

    logic [23:0] w_lfsr_code;
    logic        w_lfsr_latch, w_user_latch, w_user_clear;
    logic [3:0]  w_user_digit;
    logic        w_unlock, w_reset_sys, w_expired, w_locked;
    logic [3:0]  w_wrng, w_digit_cnt;
    logic [23:0] w_otp, w_user_otp;
    logic [2:0]  w_state;

    int n_checks = 0;
    int n_pass   = 0;

    otp_auth_ctrl #(.N_DIGITS(4), .DIGIT_W(4), .MAX_ATTEMPTS(3), .EXPIRE_CYCLES(EXP),
                    .HOLD_CYCLES(HOLD), .LOCKOUT_CYCLES(LOCK)) u_dut (
        .clk(clk), .reset(reset), .lfsr_code(lfsr_code), .lfsr_latch(lfsr_latch),
        .user_digit(user_digit), .user_latch(user_latch), .user_clear(user_clear),
        .unlock(unlock), .reset_sys(reset_sys), .expired(expired), .locked(locked),
        .wrng_atmpt(wrng_atmpt), .otp(otp), .user_otp_out(user_otp_out),
        .digit_cnt(digit_cnt), .state_out(state_out));

    otp_auth_ctrl #(.N_DIGITS(6), .DIGIT_W(4), .MAX_ATTEMPTS(3), .EXPIRE_CYCLES(EXP),
                    .HOLD_CYCLES(HOLD), .LOCKOUT_CYCLES(LOCK)) u_wide (
        .clk(clk), .reset(reset), .lfsr_code(w_lfsr_code), .lfsr_latch(w_lfsr_latch),
        .user_digit(w_user_digit), .user_latch(w_user_latch), .user_clear(w_user_clear),
        .unlock(w_unlock), .reset_sys(w_reset_sys), .expired(w_expired), .locked(w_locked),
        .wrng_atmpt(w_wrng), .otp(w_otp), .user_otp_out(w_user_otp),
        .digit_cnt(w_digit_cnt), .state_out(w_state));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_digit(input logic [3:0] d);
        user_digit = d;
        user_latch = 1'b1;
        step();
        user_latch = 1'b0;
    endtask

    task automatic w_enter_digit(input logic [3:0] d);
        w_user_digit = d;
        w_user_latch = 1'b1;
        step();
        w_user_latch = 1'b0;
    endtask

    task automatic capture(input logic [15:0] code);
        lfsr_code  = code;
        lfsr_latch = 1'b1;
        step();
        lfsr_latch = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        lfsr_code = '0; lfsr_latch = 0; user_digit = '0; user_latch = 0; user_clear = 0;
        w_lfsr_code = '0; w_lfsr_latch = 0; w_user_digit = '0; w_user_latch = 0; w_user_clear = 0;
        step();
        step();
        n_checks++;
        if (state_out !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state_out); else n_pass++;
        n_checks++;
        if ({unlock, reset_sys, expired, locked} !== 4'b0)
            $display("FAIL reset_flags: got %b expected 0000", {unlock, reset_sys, expired, locked});
        else n_pass++;
        n_checks++;
        if ({otp, user_otp_out, digit_cnt, wrng_atmpt} !== 40'h0)
            $display("FAIL reset_data: got %h expected 0", {otp, user_otp_out, digit_cnt, wrng_atmpt});
        else n_pass++;
        reset = 1'b0;
        step();
        n_checks++;
        if (state_out !== 3'd1) $display("FAIL release_gen: got %0d expected 1", state_out); else n_pass++;
        n_checks++;
        if (w_state !== 3'd1) $display("FAIL wide_release_gen: got %0d expected 1", w_state); else n_pass++;
    endtask

    task automatic test_pass();
        int  cnt;
        bit  excl_bad;
        enter_digit(4'h9);
        n_checks++;
        if (digit_cnt !== 4'd0 || state_out !== 3'd1)
            $display("FAIL latch_ignored_gen: got cnt=%0d st=%0d expected cnt=0 st=1", digit_cnt, state_out);
        else n_pass++;
        capture(16'h3A7C);
        n_checks++;
        if (state_out !== 3'd2 || otp !== 16'h3A7C)
            $display("FAIL capture: got st=%0d otp=%h expected st=2 otp=3a7c", state_out, otp);
        else n_pass++;
        lfsr_code  = 16'hFFFF;
        lfsr_latch = 1'b1;
        enter_digit(4'h3);
        lfsr_latch = 1'b0;
        n_checks++;
        if (otp !== 16'h3A7C) $display("FAIL lfsr_ignored_enter: got %h expected 3a7c", otp); else n_pass++;
        enter_digit(4'hA);
        enter_digit(4'h7);
        enter_digit(4'hC);
        n_checks++;
        if (digit_cnt !== 4'd4 || user_otp_out !== 16'h3A7C || state_out !== 3'd2)
            $display("FAIL four_digits: got cnt=%0d user=%h st=%0d expected 4 3a7c 2", digit_cnt, user_otp_out, state_out);
        else n_pass++;
        enter_digit(4'hF);
        n_checks++;
        if (state_out !== 3'd3 || user_otp_out !== 16'h3A7C || digit_cnt !== 4'd4 || unlock !== 1'b0)
            $display("FAIL check_state: got st=%0d user=%h cnt=%0d unl=%b expected 3 3a7c 4 0",
                     state_out, user_otp_out, digit_cnt, unlock);
        else n_pass++;
        step();
        n_checks++;
        if (state_out !== 3'd4 || unlock !== 1'b1)
            $display("FAIL pass_entry: got st=%0d unl=%b expected 4 1", state_out, unlock);
        else n_pass++;
        cnt = 0;
        excl_bad = 0;
        while (unlock === 1'b1 && cnt < 30) begin
            if (reset_sys || expired || locked) excl_bad = 1;
            cnt++;
            step();
        end
        n_checks++;
        if (cnt != int'(HOLD)) $display("FAIL unlock_len: got %0d expected %0d", cnt, HOLD); else n_pass++;
        n_checks++;
        if (excl_bad) $display("FAIL flag_exclusive: got 1 expected 0"); else n_pass++;
        n_checks++;
        if (state_out !== 3'd0) $display("FAIL pass_to_idle: got %0d expected 0", state_out); else n_pass++;
        step();
        n_checks++;
        if (state_out !== 3'd1 || otp !== 16'h0 || user_otp_out !== 16'h0)
            $display("FAIL idle_clears: got st=%0d otp=%h user=%h expected 1 0 0", state_out, otp, user_otp_out);
        else n_pass++;
    endtask

    task automatic test_fail();
        int cnt;
        capture(16'h3A7C);
        for (int k = 1; k <= 3; k++) begin
            repeat (4) enter_digit(4'h1);
            step();
            step();
            n_checks++;
            if (wrng_atmpt !== 4'(k)) $display("FAIL wrng_step: got %0d expected %0d", wrng_atmpt, k); else n_pass++;
            n_checks++;
            if (state_out !== ((k < 3) ? 3'd2 : 3'd5) || (k < 3 && digit_cnt !== 4'd0))
                $display("FAIL attempt_state: got st=%0d cnt=%0d expected st=%0d cnt=0",
                         state_out, digit_cnt, (k < 3) ? 2 : 5);
            else n_pass++;
        end
        cnt = 0;
        while (reset_sys === 1'b1 && cnt < 30) begin
            cnt++;
            step();
        end
        n_checks++;
        if (cnt != int'(HOLD)) $display("FAIL reset_sys_len: got %0d expected %0d", cnt, HOLD); else n_pass++;
`ifdef OTP_LOCKOUT_EN
        n_checks++;
        if (state_out !== 3'd7 || locked !== 1'b1)
            $display("FAIL lockout_entry: got st=%0d locked=%b expected 7 1", state_out, locked);
        else n_pass++;
        cnt = 0;
        while (locked === 1'b1 && cnt < 60) begin
            cnt++;
            step();
        end
        n_checks++;
        if (cnt != int'(LOCK)) $display("FAIL locked_len: got %0d expected %0d", cnt, LOCK); else n_pass++;
`else
        n_checks++;
        if (locked !== 1'b0) $display("FAIL locked_const: got %b expected 0", locked); else n_pass++;
`endif
        n_checks++;
        if (state_out !== 3'd0) $display("FAIL fail_to_idle: got %0d expected 0", state_out); else n_pass++;
        step();
    endtask

    task automatic test_expire();
        int cnt;
        capture(16'h3A7C);
        enter_digit(4'h3);
        enter_digit(4'hA);
        repeat (int'(EXP) - 3) step();
        n_checks++;
        if (state_out !== 3'd2 || expired !== 1'b0)
            $display("FAIL pre_expiry: got st=%0d exp=%b expected 2 0", state_out, expired);
        else n_pass++;
        enter_digit(4'h5);
        n_checks++;
        if (state_out !== 3'd6 || expired !== 1'b1)
            $display("FAIL expiry_at_100: got st=%0d exp=%b expected 6 1", state_out, expired);
        else n_pass++;
        n_checks++;
        if (digit_cnt !== 4'd2 || user_otp_out !== 16'h3A00)
            $display("FAIL expiry_drops_digit: got cnt=%0d user=%h expected 2 3a00", digit_cnt, user_otp_out);
        else n_pass++;
        cnt = 0;
        while (expired === 1'b1 && cnt < 30) begin
            cnt++;
            step();
        end
        n_checks++;
        if (cnt != int'(HOLD)) $display("FAIL expired_len: got %0d expected %0d", cnt, HOLD); else n_pass++;
        n_checks++;
        if (state_out !== 3'd0) $display("FAIL expired_to_idle: got %0d expected 0", state_out); else n_pass++;
        step();
    endtask

    task automatic test_clear();
        capture(16'h3A7C);
        enter_digit(4'h3);
        enter_digit(4'hA);
        user_clear = 1'b1;
        enter_digit(4'h7);
        user_clear = 1'b0;
        n_checks++;
        if (digit_cnt !== 4'd0 || user_otp_out !== 16'h0 || state_out !== 3'd2)
            $display("FAIL clear_wins: got cnt=%0d user=%h st=%0d expected 0 0 2", digit_cnt, user_otp_out, state_out);
        else n_pass++;
        enter_digit(4'h3);
        enter_digit(4'hA);
        enter_digit(4'h7);
        enter_digit(4'hC);
        step();
        step();
        n_checks++;
        if (state_out !== 3'd4 || unlock !== 1'b1)
            $display("FAIL clear_then_unlock: got st=%0d unl=%b expected 4 1", state_out, unlock);
        else n_pass++;
    endtask

    task automatic test_reset_mid_pass();
        repeat (4) step();
        n_checks++;
        if (state_out !== 3'd4 || unlock !== 1'b1)
            $display("FAIL hold_cycle5: got st=%0d unl=%b expected 4 1", state_out, unlock);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (state_out !== 3'd0 || {unlock, reset_sys, expired, locked} !== 4'b0)
            $display("FAIL async_reset_flags: got st=%0d flags=%b expected 0 0000",
                     state_out, {unlock, reset_sys, expired, locked});
        else n_pass++;
        n_checks++;
        if ({otp, user_otp_out, digit_cnt, wrng_atmpt} !== 40'h0)
            $display("FAIL async_reset_data: got %h expected 0", {otp, user_otp_out, digit_cnt, wrng_atmpt});
        else n_pass++;
        step();
        reset = 1'b0;
        n_checks++;
        if (state_out !== 3'd0) $display("FAIL post_reset_idle: got %0d expected 0", state_out); else n_pass++;
        step();
        n_checks++;
        if (state_out !== 3'd1) $display("FAIL post_reset_gen: got %0d expected 1", state_out); else n_pass++;
    endtask

    task automatic test_width();
        w_lfsr_code  = 24'h5B19E2;
        w_lfsr_latch = 1'b1;
        step();
        w_lfsr_latch = 1'b0;
        n_checks++;
        if (w_otp !== 24'h5B19E2 || w_state !== 3'd2)
            $display("FAIL wide_capture: got otp=%h st=%0d expected 5b19e2 2", w_otp, w_state);
        else n_pass++;
        w_enter_digit(4'h5); w_enter_digit(4'hB); w_enter_digit(4'h1);
        w_enter_digit(4'h9); w_enter_digit(4'hE); w_enter_digit(4'h3);
        n_checks++;
        if (w_user_otp !== 24'h5B19E3) $display("FAIL wide_entry: got %h expected 5b19e3", w_user_otp); else n_pass++;
        step();
        step();
        n_checks++;
        if (w_wrng !== 4'd1 || w_state !== 3'd2 || w_unlock !== 1'b0)
            $display("FAIL wide_last_digit_wrong: got wrng=%0d st=%0d unl=%b expected 1 2 0", w_wrng, w_state, w_unlock);
        else n_pass++;
        w_enter_digit(4'h5); w_enter_digit(4'hB); w_enter_digit(4'h1);
        w_enter_digit(4'h9); w_enter_digit(4'hE); w_enter_digit(4'h2);
        step();
        step();
        n_checks++;
        if (w_state !== 3'd4 || w_unlock !== 1'b1 || w_wrng !== 4'd1)
            $display("FAIL wide_match: got st=%0d unl=%b wrng=%0d expected 4 1 1", w_state, w_unlock, w_wrng);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_expire();
        test_clear();
        test_reset_mid_pass();
        test_width();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/otp_auth_ctrl.md
OTP_AUTH_CTRL -- requirements
Module: otp_auth_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 4, is the number of OTP digits (2..8).
REQ-002 Parameter DIGIT_W, default 4, is the bits per digit.
REQ-003 Parameter MAX_ATTEMPTS, default 3, is the number of wrong entries that triggers failure (1..15).
REQ-004 Parameter EXPIRE_CYCLES, default 1_500_000_000, is the entry window in clk cycles, measured from OTP capture.
REQ-005 Parameter HOLD_CYCLES, default 250_000_000, is the display hold for the PASS, FAIL and EXPIRED states.
REQ-006 Parameter LOCKOUT_CYCLES, default 500_000_000, is the lockout duration (used only with OTP_LOCKOUT_EN).
REQ-007 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 Port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-009 Port lfsr_code, input, N_DIGITS*DIGIT_W bits: generated code; digit 0 occupies the MSBs.
REQ-010 Port lfsr_latch, input, 1 bit: one-cycle strobe marking lfsr_code valid.
REQ-011 Port user_digit, input, DIGIT_W bits: the digit the user entered.
REQ-012 Port user_latch, input, 1 bit: one-cycle strobe marking user_digit valid.
REQ-013 Port user_clear, input, 1 bit: one-cycle strobe that discards the partial entry.
REQ-014 Outputs unlock, reset_sys, expired and locked are each 1 bit; they are the status flags.
REQ-015 Output wrng_atmpt is 4 bits: the wrong-attempt count.
REQ-016 Output otp is N_DIGITS*DIGIT_W bits: the captured code.
REQ-017 Output user_otp_out is N_DIGITS*DIGIT_W bits: the entered digits, with digit 0 in the MSBs.
REQ-018 Output digit_cnt is 4 bits: the number of digits entered so far.
REQ-019 Output state_out is 3 bits and encodes the state as IDLE=0, GEN=1, ENTER=2, CHECK=3, PASS=4, FAIL=5, EXPIRED=6, LOCKOUT=7.

Function
REQ-020 All outputs shall be registered, and the state register shall be updated on every clock edge.
REQ-021 IDLE shall clear otp, user digits, digit_cnt, wrng_atmpt, the timers and all flags, then move to GEN on the next cycle.
REQ-022 GEN shall wait for lfsr_latch; on that strobe it shall capture lfsr_code into otp, clear the entry timer and move to ENTER.
REQ-023 In ENTER, the entry timer shall increment every cycle.
REQ-024 In ENTER, user_latch shall write user_digit into slot digit_cnt and increment digit_cnt.
REQ-025 In ENTER, user_clear shall zero all user digits and digit_cnt but leave the entry timer running; if user_clear and user_latch arrive in the same cycle, user_clear wins.
REQ-026 When digit_cnt reaches N_DIGITS, the state shall be CHECK in the following cycle, and further user_latch strobes shall be ignored.
REQ-027 When the entry timer equals EXPIRE_CYCLES-1 in ENTER, the next state shall be EXPIRED; expiry takes priority over a same-cycle user_latch, whose digit is discarded.
REQ-028 CHECK shall last exactly one cycle and compare otp against the user digits.
REQ-029 On a match in CHECK, the next state shall be PASS.
REQ-030 On a mismatch in CHECK, wrng_atmpt shall increment; if the new value equals MAX_ATTEMPTS the next state is FAIL, otherwise ENTER with digits and digit_cnt cleared and the timer not reset.
REQ-031 PASS shall hold unlock=1 for exactly HOLD_CYCLES cycles and then go to IDLE.
REQ-032 FAIL shall hold reset_sys=1 for exactly HOLD_CYCLES cycles.
REQ-033 EXPIRED shall hold expired=1 for exactly HOLD_CYCLES cycles and then go to IDLE.
REQ-034 unlock, reset_sys and expired shall be mutually exclusive.
REQ-035 user_latch and user_clear shall be ignored outside ENTER, and lfsr_latch shall be ignored outside GEN.
REQ-036 wrng_atmpt shall saturate at MAX_ATTEMPTS and never wrap.
REQ-037 The hold and lockout counters shall be 32 bits wide and cleared on entry to each timed state.

Reset
REQ-038 While reset=1, the block shall be asynchronously forced to IDLE with every output at 0.
REQ-039 Deasserting reset shall resume operation at IDLE on the next edge.
REQ-040 A reset during any state, including mid-entry or mid-hold, shall discard all progress.

Configuration
REQ-041 With OTP_LOCKOUT_EN defined, FAIL shall go to LOCKOUT after its hold; LOCKOUT holds locked=1 for LOCKOUT_CYCLES cycles and then goes to IDLE.
REQ-042 Without OTP_LOCKOUT_EN, FAIL shall go directly to IDLE, locked shall be constant 0, and the LOCKOUT state shall not be implemented.

Verification
REQ-043 Correct entry: with EXPIRE_CYCLES=100 and HOLD_CYCLES=10, lfsr_code=0x3A7C is latched, then digits 3, A, 7, C are entered -> CHECK for 1 cycle, unlock=1 for exactly 10 cycles, then IDLE.
REQ-044 Failure: three wrong entries of 0x1111 -> wrng_atmpt steps 1, 2, 3, then reset_sys=1 for 10 cycles, then IDLE, or LOCKOUT with locked=1 when OTP_LOCKOUT_EN is defined.
REQ-045 Expiry: two digits are entered and then no input is given -> expired=1 exactly 100 cycles after capture, lasting 10 cycles; a user_latch in the expiry cycle is dropped.
REQ-046 Clear: digits 3 and A are entered, then user_clear and user_latch arrive in the same cycle -> digit_cnt=0, user_otp_out=0, and a following correct entry of 4 digits unlocks.
REQ-047 Reset mid-PASS: reset is asserted in hold cycle 5 -> all outputs are 0 immediately, and after release state_out goes IDLE then GEN.
REQ-048 Width: with N_DIGITS=6 and DIGIT_W=4, a 24-bit code is matched correctly, and a mismatch in the last digit only counts as a wrong attempt.
